regfile_wb_ctrl: RTL and testbench

Write-back controller driving the single write port of the core's register file. It accepts write-back requests from two producers, the ALU and the load/memory return path, over valid/ready handshakes. Each producer has its own buffer, and the block serialises the buffered writes onto one registered `WR_addr`/`WR_data`/`wena` port. It also reports read-after-write hazards for the two register-file read addresses, so issue logic can stall on registers with writes still pending.

---
 rtl/regfile_pkg.sv | 24 ++
 rtl/wb_fifo.sv | 91 +++++++++
 rtl/regfile_wb_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_regfile_wb_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared types and default sizes for the register-file write-back controller.
//   DEF_DATAPATH_WIDTH     default write data width
//   DEF_REGFILE_ADDR_WIDTH default register address width
//   DEF_FIFO_DEPTH         default entries per source buffer
//   wb_entry_t             one buffered write {addr, data}
//   wb_src_t               write-back source identifier
package regfile_pkg;

    localparam int DEF_DATAPATH_WIDTH     = 64;
    localparam int DEF_REGFILE_ADDR_WIDTH = 5;
    localparam int DEF_FIFO_DEPTH         = 4;

    typedef struct packed {
        logic [DEF_REGFILE_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATAPATH_WIDTH-1:0]     data;
    } wb_entry_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo
// Synchronous FIFO of write-back entries with per-slot visibility so the
// owner can compare every buffered destination address against read ports.
//   clk, reset          clock, asynchronous active-low reset
//   push, push_entry    write an entry (ignored while full)
//   pop                 drop the head entry (ignored while empty)
//   head_entry          oldest entry
//   full, empty         occupancy status
//   entry_valid         per-slot occupied flag (slot order, not age order)
//   entry_addr          per-slot destination address
// DEPTH must be a power of two, at least 2.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int  DEPTH      = DEF_FIFO_DEPTH,
    parameter int  ADDR_WIDTH = DEF_REGFILE_ADDR_WIDTH,
    parameter type entry_t    = wb_entry_t
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            push,
    input  entry_t                          push_entry,
    input  logic                            pop,
    output entry_t                          head_entry,
    output logic                            full,
    output logic                            empty,
    output logic [DEPTH-1:0]                entry_valid,
    output logic [DEPTH-1:0][ADDR_WIDTH-1:0] entry_addr
);

    localparam int PTR_W = $clog2(DEPTH);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] vld_nxt;
    logic             push_ok;
    logic             pop_ok;

    // Occupancy is tracked per slot: the write slot being occupied means the
    // ring has wrapped onto the oldest entry, the read slot being free means
    // nothing is buffered.
    assign full    = vld[wr_ptr];
    assign empty   = ~vld[rd_ptr];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        vld_nxt = vld;
        if (pop_ok) begin
            vld_nxt[rd_ptr] = 1'b0;
        end
        if (push_ok) begin
            vld_nxt[wr_ptr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            vld    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            vld <= vld_nxt;
        end
    end

    // Storage needs no reset: a slot is only observed while its valid bit is set.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    assign head_entry  = mem[rd_ptr];
    assign entry_valid = vld;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_addr[i] = mem[i].addr;
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl
// Serialises ALU and load-return write-backs onto the single register-file
// write port, and flags read addresses that still have a write in flight.
//   clk, reset                         clock, asynchronous active-low reset
//   alu_valid_in/addr/data, alu_ready_out   ALU write-back handshake
//   mem_valid_in/addr/data, mem_ready_out   load-return write-back handshake
//   WR_addr_out, WR_data_out, wena_out      registered regfile write port
//   R1_addr_in, R2_addr_in                  read addresses under issue
//   R1_pending_out, R2_pending_out          combinational hazard flags
// Build option: REGFILE_WB_R0_DISCARD_EN -- writes to register 0 are accepted
// but dropped, and register 0 never reports a pending write.
//
// Arbitration pointer (only consulted when both buffers hold entries):
//   state   | meaning
//   SRC_ALU | ALU wins the next contended cycle
//   SRC_MEM | memory return wins the next contended cycle
module regfile_wb_ctrl
    import regfile_pkg::*;
#(
    parameter int DATAPATH_WIDTH     = DEF_DATAPATH_WIDTH,
    parameter int REGFILE_ADDR_WIDTH = DEF_REGFILE_ADDR_WIDTH,
    parameter int FIFO_DEPTH         = DEF_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          alu_valid_in,
    input  logic [REGFILE_ADDR_WIDTH-1:0] alu_addr_in,
    input  logic [DATAPATH_WIDTH-1:0]     alu_data_in,
    output logic                          alu_ready_out,
    input  logic                          mem_valid_in,
    input  logic [REGFILE_ADDR_WIDTH-1:0] mem_addr_in,
    input  logic [DATAPATH_WIDTH-1:0]     mem_data_in,
    output logic                          mem_ready_out,
    output logic [REGFILE_ADDR_WIDTH-1:0] WR_addr_out,
    output logic [DATAPATH_WIDTH-1:0]     WR_data_out,
    output logic                          wena_out,
    input  logic [REGFILE_ADDR_WIDTH-1:0] R1_addr_in,
    input  logic [REGFILE_ADDR_WIDTH-1:0] R2_addr_in,
    output logic                          R1_pending_out,
    output logic                          R2_pending_out
);

    // Sized from this instance's parameters so non-default widths stay consistent.
    typedef struct packed {
        logic [REGFILE_ADDR_WIDTH-1:0] addr;
        logic [DATAPATH_WIDTH-1:0]     data;
    } entry_t;

    entry_t  alu_in;
    entry_t  mem_in;
    entry_t  alu_head;
    entry_t  mem_head;
    entry_t  grant_entry;
    entry_t  wr_q;
    logic    wena_q;
    logic    alu_keep;
    logic    mem_keep;
    logic    alu_push;
    logic    mem_push;
    logic    alu_pop;
    logic    mem_pop;
    logic    alu_full;
    logic    alu_empty;
    logic    mem_full;
    logic    mem_empty;
    logic    grant;
    wb_src_t ptr_q;
    wb_src_t ptr_d;
    logic    r1_hit;
    logic    r2_hit;

    logic [FIFO_DEPTH-1:0]                         alu_vld;
    logic [FIFO_DEPTH-1:0]                         mem_vld;
    logic [FIFO_DEPTH-1:0][REGFILE_ADDR_WIDTH-1:0] alu_addrs;
    logic [FIFO_DEPTH-1:0][REGFILE_ADDR_WIDTH-1:0] mem_addrs;

`ifdef REGFILE_WB_R0_DISCARD_EN
    // Register 0 is hard-wired: its writes complete the handshake but go nowhere.
    assign alu_keep = (alu_addr_in != '0);
    assign mem_keep = (mem_addr_in != '0);
`else
    assign alu_keep = 1'b1;
    assign mem_keep = 1'b1;
`endif

    assign alu_ready_out = ~alu_full;
    assign mem_ready_out = ~mem_full;
    assign alu_push      = alu_valid_in & alu_ready_out & alu_keep;
    assign mem_push      = mem_valid_in & mem_ready_out & mem_keep;

    assign alu_in.addr = alu_addr_in;
    assign alu_in.data = alu_data_in;
    assign mem_in.addr = mem_addr_in;
    assign mem_in.data = mem_data_in;

    wb_fifo #(
        .DEPTH      (FIFO_DEPTH),
        .ADDR_WIDTH (REGFILE_ADDR_WIDTH),
        .entry_t    (entry_t)
    ) u_alu_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (alu_push),
        .push_entry  (alu_in),
        .pop         (alu_pop),
        .head_entry  (alu_head),
        .full        (alu_full),
        .empty       (alu_empty),
        .entry_valid (alu_vld),
        .entry_addr  (alu_addrs)
    );

    wb_fifo #(
        .DEPTH      (FIFO_DEPTH),
        .ADDR_WIDTH (REGFILE_ADDR_WIDTH),
        .entry_t    (entry_t)
    ) u_mem_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (mem_push),
        .push_entry  (mem_in),
        .pop         (mem_pop),
        .head_entry  (mem_head),
        .full        (mem_full),
        .empty       (mem_empty),
        .entry_valid (mem_vld),
        .entry_addr  (mem_addrs)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= SRC_ALU;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // The pointer only moves when both heads compete, so a lone source never
    // costs the other its turn.
    always_comb begin
        ptr_d       = ptr_q;
        alu_pop     = 1'b0;
        mem_pop     = 1'b0;
        if (!alu_empty && (mem_empty || ptr_q == SRC_ALU)) begin
            alu_pop = 1'b1;
        end else if (!mem_empty) begin
            mem_pop = 1'b1;
        end
        if (!alu_empty && !mem_empty) begin
            ptr_d = (ptr_q == SRC_ALU) ? SRC_MEM : SRC_ALU;
        end
        grant       = alu_pop | mem_pop;
        grant_entry = alu_pop ? alu_head : mem_head;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wena_q <= 1'b0;
            wr_q   <= '0;
        end else begin
            wena_q <= grant;
            if (grant) begin
                wr_q <= grant_entry;
            end
        end
    end

    assign wena_out    = wena_q;
    assign WR_addr_out = wr_q.addr;
    assign WR_data_out = wr_q.data;

    // A write is pending from the moment it is buffered until the regfile
    // captures it from the output register.
    always_comb begin
        r1_hit = wena_q && (wr_q.addr == R1_addr_in);
        r2_hit = wena_q && (wr_q.addr == R2_addr_in);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (alu_vld[i] && alu_addrs[i] == R1_addr_in) r1_hit = 1'b1;
            if (mem_vld[i] && mem_addrs[i] == R1_addr_in) r1_hit = 1'b1;
            if (alu_vld[i] && alu_addrs[i] == R2_addr_in) r2_hit = 1'b1;
            if (mem_vld[i] && mem_addrs[i] == R2_addr_in) r2_hit = 1'b1;
        end
    end

`ifdef REGFILE_WB_R0_DISCARD_EN
    assign R1_pending_out = r1_hit && (R1_addr_in != '0);
    assign R2_pending_out = r2_hit && (R2_addr_in != '0);
`else
    assign R1_pending_out = r1_hit;
    assign R2_pending_out = r2_hit;
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl
// Drives regfile_wb_ctrl with directed and random write-back traffic and
// compares every cycle against a queue-based reference of the write-back rules.
module tb_regfile_wb_ctrl;

    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  a;
        logic [63:0] d;
    } ent_t;

    logic        clk;
    logic        reset;
    logic        alu_valid_in;
    logic [4:0]  alu_addr_in;
    logic [63:0] alu_data_in;
    logic        alu_ready_out;
    logic        mem_valid_in;
    logic [4:0]  mem_addr_in;
    logic [63:0] mem_data_in;
    logic        mem_ready_out;
    logic [4:0]  WR_addr_out;
    logic [63:0] WR_data_out;
    logic        wena_out;
    logic [4:0]  R1_addr_in;
    logic [4:0]  R2_addr_in;
    logic        R1_pending_out;
    logic        R2_pending_out;

    regfile_wb_ctrl #(
        .DATAPATH_WIDTH     (64),
        .REGFILE_ADDR_WIDTH (5),
        .FIFO_DEPTH         (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .alu_valid_in   (alu_valid_in),
        .alu_addr_in    (alu_addr_in),
        .alu_data_in    (alu_data_in),
        .alu_ready_out  (alu_ready_out),
        .mem_valid_in   (mem_valid_in),
        .mem_addr_in    (mem_addr_in),
        .mem_data_in    (mem_data_in),
        .mem_ready_out  (mem_ready_out),
        .WR_addr_out    (WR_addr_out),
        .WR_data_out    (WR_data_out),
        .wena_out       (wena_out),
        .R1_addr_in     (R1_addr_in),
        .R2_addr_in     (R2_addr_in),
        .R1_pending_out (R1_pending_out),
        .R2_pending_out (R2_pending_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Stimulus still to be offered by each producer, and the reference view
    // of what is buffered and what sits on the write port.
    ent_t        alu_stim[$];
    ent_t        mem_stim[$];
    ent_t        alu_q[$];
    ent_t        mem_q[$];
    bit          mem_turn;
    bit          exp_wena;
    logic [4:0]  exp_addr;
    logic [63:0] exp_data;
    int          n_kept;
    int          n_dut_writes;
    int          n_dut_r0;
    logic [4:0]  out_log[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit kept(input logic [4:0] a);
`ifdef REGFILE_WB_R0_DISCARD_EN
        return a != 5'd0;
`else
        return 1'b1;
`endif
    endfunction

    function automatic bit m_pending(input logic [4:0] a);
        bit h;
        h = exp_wena && (exp_addr == a);
        foreach (alu_q[i]) if (alu_q[i].a == a) h = 1'b1;
        foreach (mem_q[i]) if (mem_q[i].a == a) h = 1'b1;
        return h;
    endfunction

    function automatic ent_t mk(input logic [4:0] a, input logic [63:0] d);
        ent_t e;
        e.a = a;
        e.d = d;
        return e;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // One clock cycle, entered and left at the falling edge.
    task automatic cycle(input bit en_a, input bit en_m, input logic [4:0] r1, input logic [4:0] r2);
        ent_t ha, hm, e;
        bit   av, mv, a_acc, m_acc, a_ne, m_ne, g;
        av = en_a && alu_stim.size() > 0;
        mv = en_m && mem_stim.size() > 0;
        ha = av ? alu_stim[0] : mk(5'($urandom), rnd64());
        hm = mv ? mem_stim[0] : mk(5'($urandom), rnd64());
        alu_valid_in = av;  alu_addr_in = ha.a;  alu_data_in = ha.d;
        mem_valid_in = mv;  mem_addr_in = hm.a;  mem_data_in = hm.d;
        R1_addr_in = r1;
        R2_addr_in = r2;
        #1;
        check("alu_ready", alu_ready_out, alu_q.size() < DEPTH);
        check("mem_ready", mem_ready_out, mem_q.size() < DEPTH);
        check("r1_pending", R1_pending_out, m_pending(r1));
        check("r2_pending", R2_pending_out, m_pending(r2));
        @(posedge clk);
        a_acc = av && alu_q.size() < DEPTH;
        m_acc = mv && mem_q.size() < DEPTH;
        a_ne  = alu_q.size() > 0;
        m_ne  = mem_q.size() > 0;
        g     = 1'b0;
        if (a_ne && (!m_ne || !mem_turn)) begin
            e = alu_q.pop_front();
            g = 1'b1;
        end else if (m_ne) begin
            e = mem_q.pop_front();
            g = 1'b1;
        end
        if (a_ne && m_ne) mem_turn = !mem_turn;
        exp_wena = g;
        if (g) begin
            exp_addr = e.a;
            exp_data = e.d;
        end
        if (a_acc) begin
            alu_stim.delete(0);
            if (kept(ha.a)) begin
                alu_q.push_back(ha);
                n_kept++;
            end
        end
        if (m_acc) begin
            mem_stim.delete(0);
            if (kept(hm.a)) begin
                mem_q.push_back(hm);
                n_kept++;
            end
        end
        #1;
        check("wena", wena_out, exp_wena);
        check("wr_addr", WR_addr_out, exp_addr);
        check("wr_data", WR_data_out, exp_data);
        if (wena_out) begin
            n_dut_writes++;
            out_log.push_back(WR_addr_out);
            if (WR_addr_out == 5'd0) n_dut_r0++;
        end
        @(negedge clk);
    endtask

    task automatic drain(input int budget, input logic [4:0] r1, input logic [4:0] r2);
        int n = 0;
        while ((alu_stim.size() > 0 || mem_stim.size() > 0 || alu_q.size() > 0 ||
                mem_q.size() > 0 || exp_wena) && n < budget) begin
            cycle(1'b1, 1'b1, r1, r2);
            n++;
        end
        check("drain_timeout", n < budget, 1'b1);
    endtask

    task automatic model_reset();
        alu_q.delete();
        mem_q.delete();
        alu_stim.delete();
        mem_stim.delete();
        mem_turn     = 1'b0;
        exp_wena     = 1'b0;
        exp_addr     = '0;
        exp_data     = '0;
        n_kept       = 0;
        n_dut_writes = 0;
        n_dut_r0     = 0;
    endtask

    initial begin
        logic [4:0] exp_seq[$];
        reset        = 1'b0;
        alu_valid_in = 1'b0;  alu_addr_in = '0;  alu_data_in = '0;
        mem_valid_in = 1'b0;  mem_addr_in = '0;  mem_data_in = '0;
        R1_addr_in   = '0;    R2_addr_in  = '0;
        model_reset();
        repeat (2) @(negedge clk);

        // Reset state
        for (int i = 0; i < 4; i++) begin
            R1_addr_in = 5'($urandom);
            R2_addr_in = 5'($urandom);
            #1;
            check("rst_wena", wena_out, 1'b0);
            check("rst_r1_pending", R1_pending_out, 1'b0);
            check("rst_r2_pending", R2_pending_out, 1'b0);
        end
        check("rst_wr_addr", WR_addr_out, 5'd0);
        check("rst_wr_data", WR_data_out, 64'd0);
        check("rst_alu_ready", alu_ready_out, 1'b1);
        check("rst_mem_ready", mem_ready_out, 1'b1);
        @(negedge clk);
        reset = 1'b1;

        // Single ALU write
        alu_stim.push_back(mk(5'd3, 64'hDEAD));
        cycle(1'b1, 1'b0, 5'd3, 5'd3);
        cycle(1'b1, 1'b0, 5'd3, 5'd3);
        check("single_wena", wena_out, 1'b1);
        check("single_addr", WR_addr_out, 5'd3);
        check("single_data", WR_data_out, 64'hDEAD);
        check("single_pending_hold", R1_pending_out, 1'b1);
        cycle(1'b1, 1'b0, 5'd3, 5'd3);
        cycle(1'b1, 1'b0, 5'd3, 5'd3);
        check("single_pending_clear", R1_pending_out, 1'b0);

        // Both sources saturated with distinct addresses
        out_log.delete();
        for (int i = 1; i <= 8; i++) begin
            alu_stim.push_back(mk(5'(i), rnd64()));
            mem_stim.push_back(mk(5'(i + 16), rnd64()));
        end
        drain(100, 5'd1, 5'd17);
        for (int i = 1; i <= 8; i++) begin
            exp_seq.push_back(5'(i));
            exp_seq.push_back(5'(i + 16));
        end
        check("sat_count", out_log.size(), exp_seq.size());
        foreach (exp_seq[i]) if (i < out_log.size()) check("sat_order", out_log[i], exp_seq[i]);

        // MEM buffer filling while the ALU streams
        for (int i = 0; i < 12; i++) alu_stim.push_back(mk(5'(1 + i), rnd64()));
        for (int i = 0; i < 5; i++)  mem_stim.push_back(mk(5'(20 + i), rnd64()));
        drain(100, 5'd24, 5'd2);
        check("no_loss_dup", n_dut_writes, n_kept);

        // Register 0 handling
        out_log.delete();
        exp_seq.delete();
        n_dut_r0 = 0;
        alu_stim.push_back(mk(5'd0, rnd64()));
        alu_stim.push_back(mk(5'd5, rnd64()));
        drain(20, 5'd5, 5'd0);
`ifdef REGFILE_WB_R0_DISCARD_EN
        exp_seq.push_back(5'd5);
`else
        exp_seq.push_back(5'd0);
        exp_seq.push_back(5'd5);
`endif
        check("r0_count", out_log.size(), exp_seq.size());
        foreach (exp_seq[i]) if (i < out_log.size()) check("r0_order", out_log[i], exp_seq[i]);

        // Reset mid-stream
        for (int i = 0; i < 6; i++) begin
            alu_stim.push_back(mk(5'(i + 1), rnd64()));
            mem_stim.push_back(mk(5'(i + 9), rnd64()));
        end
        repeat (3) cycle(1'b1, 1'b1, 5'd2, 5'd10);
        check("pre_reset_wena", wena_out, 1'b1);
        alu_valid_in = 1'b0;
        mem_valid_in = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_wena", wena_out, 1'b0);
        check("async_reset_alu_ready", alu_ready_out, 1'b1);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (4) cycle(1'b0, 1'b0, 5'($urandom), 5'($urandom));

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if (alu_stim.size() < 3) alu_stim.push_back(mk(5'($urandom), rnd64()));
            if (mem_stim.size() < 3) mem_stim.push_back(mk(5'($urandom), rnd64()));
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  5'($urandom), 5'($urandom));
        end
        drain(100, 5'($urandom), 5'($urandom));
        check("rand_no_loss_dup", n_dut_writes, n_kept);
`ifdef REGFILE_WB_R0_DISCARD_EN
        check("r0_never_written", n_dut_r0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
